// File: rtl/sram_confreg_pkg.sv
// Shared constants and helpers for the data-SRAM responder:
// the config-window base, register offsets and the byte-lane mask expansion.
package sram_confreg_pkg;

  localparam logic [15:0] CONF_BASE    = 16'hBFAF;

  localparam logic [15:0] LED_ADDR     = 16'hF000;
  localparam logic [15:0] NUM_ADDR     = 16'hF010;
  localparam logic [15:0] SWITCH_ADDR  = 16'hF020;
  localparam logic [15:0] TIMER_ADDR   = 16'hE000;
  localparam logic [15:0] COMPARE_ADDR = 16'hE004;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_CONF = 2'd2
  } rd_src_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] wen);
    return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/sram_confreg_if.sv
// CPU data-SRAM port bundle; the CPU drives it as master, the responder is the slave.
interface sram_confreg_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface

// File: rtl/sram_confreg_sync_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
// The read register only changes on a read, so its output holds between reads.
module sync_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    wen_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (wen_i == 4'h0) begin
        rdata_q <= mem_q[addr_i];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wen_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_confreg.sv
// Data-SRAM responder: decodes CPU requests to the word RAM or the config
// window (LED, display, switches, timer) and returns read data one cycle later.
module sram_confreg #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] CONF_BASE = sram_confreg_pkg::CONF_BASE
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_confreg_if.slave        bus,
  input  logic [7:0]           switch,
  output logic [15:0]          led,
  output logic [31:0]          num_data,
  output logic                 timer_irq
);

  import sram_confreg_pkg::*;

  logic        conf_hit, rd_req, wr_req, conf_wr;
  logic [15:0] offset;
  logic [31:0] wmask, ram_rdata, conf_rvalue;

  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        irq_q, irq_d;
  rd_src_e     rd_src_q, rd_src_d;
  logic [31:0] conf_rdata_q, conf_rdata_d;

  assign conf_hit = (bus.data_sram_addr[31:16] == CONF_BASE);
  assign offset   = bus.data_sram_addr[15:0];
  assign rd_req   = bus.data_sram_en && (bus.data_sram_wen == 4'h0);
  assign wr_req   = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
  assign conf_wr  = wr_req && conf_hit;
  assign wmask    = byte_mask(bus.data_sram_wen);

  sync_ram #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .en_i    (bus.data_sram_en && !conf_hit),
    .wen_i   (bus.data_sram_wen),
    .addr_i  (bus.data_sram_addr[RAM_AW+1:2]),
    .wdata_i (bus.data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    conf_rvalue = 32'h0;
    case (offset)
      LED_ADDR:     conf_rvalue = {16'h0, led_q};
      NUM_ADDR:     conf_rvalue = num_q;
      SWITCH_ADDR:  conf_rvalue = {24'h0, sw_sync_q};
      TIMER_ADDR:   conf_rvalue = timer_q;
      COMPARE_ADDR: conf_rvalue = compare_q;
      default:      conf_rvalue = 32'h0;
    endcase
  end

  // A write to the timer replaces that cycle's increment.
  always_comb begin
    logic [31:0] led_merged;
    led_merged   = ({16'h0, led_q} & ~wmask) | (bus.data_sram_wdata & wmask);
    led_d        = led_q;
    num_d        = num_q;
    compare_d    = compare_q;
    timer_d      = timer_q + 32'd1;
    if (conf_wr) begin
      case (offset)
        LED_ADDR:     led_d     = led_merged[15:0];
        NUM_ADDR:     num_d     = (num_q & ~wmask) | (bus.data_sram_wdata & wmask);
        TIMER_ADDR:   timer_d   = (timer_q & ~wmask) | (bus.data_sram_wdata & wmask);
        COMPARE_ADDR: compare_d = (compare_q & ~wmask) | (bus.data_sram_wdata & wmask);
        default:      ;
      endcase
    end
    irq_d        = (compare_q != 32'h0) && (timer_q == compare_q);
    rd_src_d     = rd_src_q;
    conf_rdata_d = conf_rdata_q;
    if (rd_req) begin
      rd_src_d = conf_hit ? SRC_CONF : SRC_RAM;
      if (conf_hit) conf_rdata_d = conf_rvalue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q        <= 16'h0;
      num_q        <= 32'h0;
      timer_q      <= 32'h0;
      compare_q    <= 32'h0;
      sw_meta_q    <= 8'h0;
      sw_sync_q    <= 8'h0;
      irq_q        <= 1'b0;
      rd_src_q     <= SRC_NONE;
      conf_rdata_q <= 32'h0;
    end else begin
      led_q        <= led_d;
      num_q        <= num_d;
      timer_q      <= timer_d;
      compare_q    <= compare_d;
      sw_meta_q    <= switch;
      sw_sync_q    <= sw_meta_q;
      irq_q        <= irq_d;
      rd_src_q     <= rd_src_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  always_comb begin
    bus.data_sram_rdata = 32'h0;
    case (rd_src_q)
      SRC_RAM:  bus.data_sram_rdata = ram_rdata;
      SRC_CONF: bus.data_sram_rdata = conf_rdata_q;
      default:  bus.data_sram_rdata = 32'h0;
    endcase
  end

  assign led       = ~led_q;
  assign num_data  = num_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_sram_confreg.sv
// Directed self-checking bench for sram_confreg: RAM, config registers,
// timer/irq, switch synchroniser, back-to-back reads and reset behaviour.
module tb_sram_confreg;

  logic        clk;
  logic        reset;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_irq;

  int nCompared;
  int nMismatched;

  sram_confreg_if bus ();

  sram_confreg dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .switch    (switch),
    .led       (led),
    .num_data  (num_data),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] wen,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen);
    applyStimulus(1'b1, wen, addr, wdata);
    tick();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic busRead(input logic [31:0] addr);
    applyStimulus(1'b1, 4'h0, addr, 32'h0);
    tick();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nCompared++; if (bus.data_sram_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h want %h", bus.data_sram_rdata, 32'h0); end
    nCompared++; if (led !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL reset_led: got %h want %h", led, 16'hFFFF); end
    nCompared++; if (num_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_num: got %h want %h", num_data, 32'h0); end
    nCompared++; if (timer_irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_irq: got %b want 0", timer_irq); end
  endtask

  task automatic test_timer();
    doReset();
    for (int i = 0; i < 10; i++) begin
      tick();
      nCompared++; if (timer_irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL irq_compare_zero: cycle %0d got %b want 0", i, timer_irq); end
    end
    busRead(32'hBFAF_E000);
    nCompared++; if (bus.data_sram_rdata !== 32'd10) begin nMismatched++; $display("[TB] FAIL timer_after_idle: got %h want %h", bus.data_sram_rdata, 32'd10); end
    busWrite(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
    repeat (3) tick();
    busRead(32'hBFAF_E000);
    nCompared++; if (bus.data_sram_rdata !== 32'h1) begin nMismatched++; $display("[TB] FAIL timer_wrap: got %h want %h", bus.data_sram_rdata, 32'h1); end
    busWrite(32'hBFAF_E000, 32'h0000_00AB, 4'h1);
    busRead(32'hBFAF_E000);
    nCompared++; if (bus.data_sram_rdata !== 32'h0000_00AB) begin nMismatched++; $display("[TB] FAIL timer_masked_write: got %h want %h", bus.data_sram_rdata, 32'h0000_00AB); end
  endtask

  task automatic test_irq();
    int pulses;
    busWrite(32'hBFAF_E000, 32'h0000_0100, 4'hF);
    busWrite(32'hBFAF_E004, 32'h0000_0020, 4'hF);
    busWrite(32'hBFAF_E000, 32'h0000_001E, 4'hF);
    nCompared++; if (timer_irq !== 1'b0) begin nMismatched++; $display("[TB] FAIL irq_at_write: got %b want 0", timer_irq); end
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (timer_irq === 1'b1) pulses++;
      nCompared++; if (timer_irq !== (k == 3)) begin nMismatched++; $display("[TB] FAIL irq_cycle%0d: got %b want %b", k, timer_irq, (k == 3)); end
    end
    nCompared++; if (pulses !== 1) begin nMismatched++; $display("[TB] FAIL irq_pulse_count: got %0d want 1", pulses); end
    busRead(32'hBFAF_E004);
    nCompared++; if (bus.data_sram_rdata !== 32'h20) begin nMismatched++; $display("[TB] FAIL compare_readback: got %h want %h", bus.data_sram_rdata, 32'h20); end
  endtask

  task automatic test_ram();
    busWrite(32'h0000_0100, 32'h1234_5678, 4'hF);
    busWrite(32'h0000_0100, 32'hAABB_CCDD, 4'h2);
    busRead(32'h0000_0100);
    nCompared++; if (bus.data_sram_rdata !== 32'h1234_CC78) begin nMismatched++; $display("[TB] FAIL ram_byte_write: got %h want %h", bus.data_sram_rdata, 32'h1234_CC78); end
    busRead(32'h0001_0102);
    nCompared++; if (bus.data_sram_rdata !== 32'h1234_CC78) begin nMismatched++; $display("[TB] FAIL ram_alias: got %h want %h", bus.data_sram_rdata, 32'h1234_CC78); end
    busWrite(32'h0000_0104, 32'hCAFE_F00D, 4'hC);
    busRead(32'h0000_0104);
    nCompared++; if (bus.data_sram_rdata[31:16] !== 16'hCAFE) begin nMismatched++; $display("[TB] FAIL ram_upper_half: got %h want %h", bus.data_sram_rdata[31:16], 16'hCAFE); end
  endtask

  task automatic test_led_num();
    busWrite(32'hBFAF_F000, 32'h0000_0F0F, 4'hF);
    nCompared++; if (led !== 16'hF0F0) begin nMismatched++; $display("[TB] FAIL led_out: got %h want %h", led, 16'hF0F0); end
    busRead(32'hBFAF_F000);
    nCompared++; if (bus.data_sram_rdata !== 32'h0000_0F0F) begin nMismatched++; $display("[TB] FAIL led_readback: got %h want %h", bus.data_sram_rdata, 32'h0000_0F0F); end
    busWrite(32'hBFAF_F010, 32'hDEAD_BEEF, 4'hF);
    busWrite(32'hBFAF_F010, 32'h0000_0011, 4'h1);
    nCompared++; if (num_data !== 32'hDEAD_BE11) begin nMismatched++; $display("[TB] FAIL num_masked: got %h want %h", num_data, 32'hDEAD_BE11); end
    busWrite(32'hBFAF_F020, 32'hFFFF_FFFF, 4'hF);
    busWrite(32'hBFAF_F100, 32'hFFFF_FFFF, 4'hF);
    nCompared++; if (led !== 16'hF0F0) begin nMismatched++; $display("[TB] FAIL led_unmapped_write: got %h want %h", led, 16'hF0F0); end
  endtask

  task automatic test_switch();
    switch = 8'hA5;
    tick();
    applyStimulus(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    tick();
    nCompared++; if (bus.data_sram_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL switch_early: got %h want %h", bus.data_sram_rdata, 32'h0); end
    tick();
    nCompared++; if (bus.data_sram_rdata !== 32'h0000_00A5) begin nMismatched++; $display("[TB] FAIL switch_synced: got %h want %h", bus.data_sram_rdata, 32'h0000_00A5); end
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    busRead(32'hBFAF_F100);
    nCompared++; if (bus.data_sram_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL unmapped_read: got %h want %h", bus.data_sram_rdata, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0001;
    vals[1] = 32'h2222_0002;
    vals[2] = 32'h3333_0003;
    for (int i = 0; i < 3; i++) busWrite(32'h0000_0200 + 32'(4*i), vals[i], 4'hF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'h0, 32'h0000_0200 + 32'(4*i), 32'h0);
      tick();
      nCompared++; if (bus.data_sram_rdata !== vals[i]) begin nMismatched++; $display("[TB] FAIL b2b_read%0d: got %h want %h", i, bus.data_sram_rdata, vals[i]); end
    end
    applyStimulus(1'b0, 4'h0, 32'h0000_0100, 32'h0);
    repeat (2) tick();
    nCompared++; if (bus.data_sram_rdata !== vals[2]) begin nMismatched++; $display("[TB] FAIL rdata_hold: got %h want %h", bus.data_sram_rdata, vals[2]); end
  endtask

  task automatic test_reset_inflight();
    applyStimulus(1'b1, 4'h0, 32'h0000_0204, 32'h0);
    tick();
    nCompared++; if (bus.data_sram_rdata !== 32'h2222_0002) begin nMismatched++; $display("[TB] FAIL inflight_pre: got %h want %h", bus.data_sram_rdata, 32'h2222_0002); end
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nCompared++; if (bus.data_sram_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL inflight_rdata: got %h want %h", bus.data_sram_rdata, 32'h0); end
    nCompared++; if (led !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL inflight_led: got %h want %h", led, 16'hFFFF); end
    nCompared++; if (num_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL inflight_num: got %h want %h", num_data, 32'h0); end
    tick();
    nCompared++; if (bus.data_sram_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL post_reset_rdata: got %h want %h", bus.data_sram_rdata, 32'h0); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    switch      = 8'h00;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_timer();
    test_irq();
    test_ram();
    test_led_num();
    test_switch();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
